btb_maint_ctrl: RTL and testbench
=================================

Name: btb_maint_ctrl

Overview:
Maintenance controller for the BTB entry array (multi-bank RAM, WRITE_NUM write ports). It sequences the post-reset initialization sweep and software-requested flushes (e.g. fence.i, context switch). During normal operation it passes branch-update writes from the IntEx stage straight to the RAM write ports. It sits between the update path and the RAM write ports and drives a hold signal to fetch while BTB contents are invalid.

Parameters:
ENTRY_NUM, 1024, number of BTB entries; power of 2, multiple of WRITE_NUM
WRITE_NUM, 2, RAM write ports (= INT_ISSUE_WIDTH); power of 2
ENTRY_BITS, 48, width of one BTB entry; all-zero means invalid
CNT_BITS, 16, width of the dropped-update counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flushReq  in  1  single-cycle request to invalidate the whole BTB
flushAck  out  1  one-cycle pulse when a flush-triggered sweep completes
busy  out  1  sweep in progress
fetchHold  out  1  fetch must ignore BTB hits; equals busy
updWe  in  WRITE_NUM  update write enables from IntEx
updWa  in  WRITE_NUM x log2(ENTRY_NUM)  update write indices
updWv  in  WRITE_NUM x ENTRY_BITS  update write data
ramWe  out  WRITE_NUM  RAM write enables
ramWa  out  WRITE_NUM x log2(ENTRY_NUM)  RAM write indices
ramWv  out  WRITE_NUM x ENTRY_BITS  RAM write data
dropCnt  out  CNT_BITS  saturating count of update writes discarded during sweeps

Behaviour:
- Reset is synchronous and active-high, on clk.
- States: SWEEP_INIT, IDLE, SWEEP_FLUSH. SWEEP_INIT and SWEEP_FLUSH behave identically except for flushAck.
- Registers: state, sweepIdx (log2 ENTRY_NUM bits), ackPending, dropCnt.
- While rst is high:
  - state=SWEEP_INIT, sweepIdx=0, dropCnt=0.
  - Outputs: ramWe=0, busy=1, fetchHold=1, flushAck=0.
- Sweep cycle (either SWEEP state, rst low):
  - ramWe[k]=1, ramWa[k]=sweepIdx+k, ramWv[k]=0 for k in 0..WRITE_NUM-1.
  - Consecutive indices go to distinct banks, so no conflicts.
  - sweepIdx += WRITE_NUM. A sweep takes ENTRY_NUM/WRITE_NUM cycles.
- Last beat (sweepIdx == ENTRY_NUM-WRITE_NUM): next state IDLE, sweepIdx wraps to 0.
- flushAck pulses in the first IDLE cycle only if the completed sweep was SWEEP_FLUSH.
- IDLE:
  - ramWe/ramWa/ramWv = updWe/updWa/updWv, combinational, zero latency.
  - busy=0, fetchHold=0.
- flushReq in IDLE: next state SWEEP_FLUSH, sweepIdx=0. busy rises the next cycle; the current cycle's updates are still passed through.
- flushReq during any sweep cycle, including the last beat: merged into the current sweep, no restart. If the state is SWEEP_INIT it is promoted to SWEEP_FLUSH, so exactly one flushAck results. This is safe because no updates are written during a sweep.
- Update requests during a sweep are not written. dropCnt += popcount(updWe), saturating at 2^CNT_BITS-1.
- rst asserted mid-sweep: abort and restart as SWEEP_INIT from index 0. Any pending flushAck is cancelled.
- busy and fetchHold are decoded from registered state only (glitch-free).

Decomposition:
- FetchUnitTypes package adds: BTB_MaintState enum; BTB_SWEEP_BEATS = BTB_ENTRY_NUM/INT_ISSUE_WIDTH; function PopCountWE.
- Entry and index types reuse BTB_Entry and BTB_IndexPath.
- One sub-module, btb_sweep_counter: sweepIdx register with clear, step-by-WRITE_NUM and lastBeat output.
- The FSM, mux and drop counter stay in btb_maint_ctrl.

Test Plan (ENTRY_NUM=16, WRITE_NUM=2):
- Release rst -> exactly 8 sweep cycles writing pairs (0,1),(2,3)…(14,15), all ramWv=0; busy=1 throughout, then 0; no flushAck.
- IDLE, updWe=2'b11, updWa=(5,9), updWv=(A,B) -> same values on ramWe/ramWa/ramWv in the same cycle; dropCnt unchanged.
- flushReq pulse in IDLE at cycle t -> busy=1 at t+1; 8 sweep beats t+1..t+8; flushAck=1 only at t+9.
- flushReq again at beat 4 of a flush sweep -> no restart, sweep ends at the original beat 8, exactly one flushAck.
- updWe=2'b11 on all 8 beats of the init sweep -> no update reaches the RAM, dropCnt=16. With CNT_BITS=4 -> dropCnt saturates at 15.
- rst for 1 cycle at beat 5 of a flush sweep -> a full 8-beat SWEEP_INIT follows from index 0; flushAck never asserts.

Source files
------------

// File: rtl/btb_maint_ctrl_pkg.sv
// Shared types, defaults and helpers for the BTB maintenance controller.
package btb_maint_ctrl_pkg;

  localparam int BTB_ENTRY_NUM   = 1024;
  localparam int INT_ISSUE_WIDTH = 2;
  localparam int BTB_ENTRY_BITS  = 48;
  localparam int BTB_INDEX_BITS  = $clog2(BTB_ENTRY_NUM);
  localparam int BTB_SWEEP_BEATS = BTB_ENTRY_NUM / INT_ISSUE_WIDTH;

  // All-zero entry is the invalid encoding, so a sweep simply writes zeros.
  typedef logic [BTB_ENTRY_BITS-1:0] btb_entry_t;
  typedef logic [BTB_INDEX_BITS-1:0] btb_index_t;

  typedef enum logic [1:0] {
    SWEEP_INIT  = 2'd0,
    IDLE        = 2'd1,
    SWEEP_FLUSH = 2'd2
  } btb_maint_state_e;

  // Number of asserted write enables (callers zero-extend to 32 bits).
  function automatic logic [5:0] pop_count_we(input logic [31:0] we);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, we[i]};
    return n;
  endfunction

endpackage

// File: rtl/btb_maint_ctrl_if.sv
// Update-path / RAM-write-path bundle around the BTB maintenance controller.
interface btb_maint_ctrl_if #(
  parameter int WRITE_NUM  = 2,
  parameter int IDX_BITS   = 10,
  parameter int ENTRY_BITS = 48,
  parameter int CNT_BITS   = 16
);
  logic                                  flushReq;
  logic                                  flushAck;
  logic                                  busy;
  logic                                  fetchHold;
  logic [WRITE_NUM-1:0]                  updWe;
  logic [WRITE_NUM-1:0][IDX_BITS-1:0]    updWa;
  logic [WRITE_NUM-1:0][ENTRY_BITS-1:0]  updWv;
  logic [WRITE_NUM-1:0]                  ramWe;
  logic [WRITE_NUM-1:0][IDX_BITS-1:0]    ramWa;
  logic [WRITE_NUM-1:0][ENTRY_BITS-1:0]  ramWv;
  logic [CNT_BITS-1:0]                   dropCnt;

  // Requester side: fetch/IntEx/software, observing RAM writes.
  modport master (
    output flushReq, updWe, updWa, updWv,
    input  flushAck, busy, fetchHold, ramWe, ramWa, ramWv, dropCnt
  );

  // Controller side.
  modport slave (
    input  flushReq, updWe, updWa, updWv,
    output flushAck, busy, fetchHold, ramWe, ramWa, ramWv, dropCnt
  );
endinterface

// File: rtl/btb_maint_ctrl_sweep_counter.sv
// Sweep index register: clears, steps by WRITE_NUM, flags the final beat.
module btb_sweep_counter #(
  parameter int ENTRY_NUM = 1024,
  parameter int WRITE_NUM = 2,
  localparam int IDX_BITS = $clog2(ENTRY_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                step,
  output logic [IDX_BITS-1:0] idx,
  output logic                last_beat
);

  // ENTRY_NUM is a power of two, so stepping past the last beat wraps to 0.
  always_ff @(posedge clk) begin
    if (rst || clr) idx <= '0;
    else if (step)  idx <= idx + IDX_BITS'(WRITE_NUM);
  end

  // Last beat covers indices ENTRY_NUM-WRITE_NUM .. ENTRY_NUM-1.
  always_comb last_beat = (idx == IDX_BITS'(ENTRY_NUM - WRITE_NUM));

endmodule

// File: rtl/btb_maint_ctrl.sv
// BTB maintenance controller: init/flush sweeps, update pass-through, drop count.
module btb_maint_ctrl
  import btb_maint_ctrl_pkg::*;
#(
  parameter int ENTRY_NUM  = BTB_ENTRY_NUM,
  parameter int WRITE_NUM  = INT_ISSUE_WIDTH,
  parameter int ENTRY_BITS = BTB_ENTRY_BITS,
  parameter int CNT_BITS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  btb_maint_ctrl_if.slave  bus
);

  localparam int IDX_BITS = $clog2(ENTRY_NUM);

  btb_maint_state_e    state, state_nxt;
  logic                ack_pending, ack_nxt;
  logic [CNT_BITS-1:0] drop_cnt;
  logic [CNT_BITS:0]   drop_sum;
  logic [IDX_BITS-1:0] sweep_idx;
  logic                last_beat;
  logic                sweeping;
  logic                clr;

  // Any non-IDLE encoding is treated as a sweep so an illegal state still holds fetch.
  always_comb sweeping = (state != IDLE);

  btb_sweep_counter #(.ENTRY_NUM(ENTRY_NUM), .WRITE_NUM(WRITE_NUM)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .step      (sweeping),
    .idx       (sweep_idx),
    .last_beat (last_beat)
  );

  // Next state: a flush during a sweep merges into it and marks it as a flush.
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.flushReq) begin
          state_nxt = SWEEP_FLUSH;
          clr       = 1'b1;
        end
      end
      SWEEP_INIT, SWEEP_FLUSH: begin
        if (last_beat) begin
          state_nxt = IDLE;
          ack_nxt   = (state == SWEEP_FLUSH) || bus.flushReq;
        end else if (bus.flushReq) begin
          state_nxt = SWEEP_FLUSH;
        end
      end
      default: state_nxt = SWEEP_INIT;
    endcase
  end

  // State and pending-ack registers; reset always restarts an init sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SWEEP_INIT;
      ack_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      ack_pending <= ack_nxt;
    end
  end

  // Saturating sum of update enables discarded during a sweep.
  always_comb begin
    drop_sum = {1'b0, drop_cnt}
             + (CNT_BITS+1)'(pop_count_we(32'(bus.updWe)));
  end

  // Drop counter update; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst)           drop_cnt <= '0;
    else if (sweeping) drop_cnt <= drop_sum[CNT_BITS] ? '1 : drop_sum[CNT_BITS-1:0];
  end

  // RAM write mux: sweep writes zero to consecutive indices, else update pass-through.
  for (genvar k = 0; k < WRITE_NUM; k++) begin : g_lane
    always_comb begin
      if (rst) begin
        bus.ramWe[k] = 1'b0;
        bus.ramWa[k] = bus.updWa[k];
        bus.ramWv[k] = bus.updWv[k];
      end else if (sweeping) begin
        bus.ramWe[k] = 1'b1;
        bus.ramWa[k] = sweep_idx + IDX_BITS'(k);
        bus.ramWv[k] = '0;
      end else begin
        bus.ramWe[k] = bus.updWe[k];
        bus.ramWa[k] = bus.updWa[k];
        bus.ramWv[k] = bus.updWv[k];
      end
    end
  end

  // Status outputs come straight from registers so they cannot glitch.
  assign bus.busy      = sweeping;
  assign bus.fetchHold = sweeping;
  assign bus.flushAck  = ack_pending;
  assign bus.dropCnt   = drop_cnt;

endmodule

// File: tb/tb_btb_maint_ctrl.sv
// Randomized bench for btb_maint_ctrl against a cycle-level behavioural model.
module tb_btb_maint_ctrl;
  localparam int EN = 16;
  localparam int WN = 2;
  localparam int EB = 48;
  localparam int IB = 4;
  localparam int BEATS = EN / WN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btb_maint_ctrl_if #(.WRITE_NUM(WN), .IDX_BITS(IB), .ENTRY_BITS(EB), .CNT_BITS(16)) bm ();
  btb_maint_ctrl_if #(.WRITE_NUM(WN), .IDX_BITS(IB), .ENTRY_BITS(EB), .CNT_BITS(4))  bs ();

  assign bs.flushReq = bm.flushReq;
  assign bs.updWe    = bm.updWe;
  assign bs.updWa    = bm.updWa;
  assign bs.updWv    = bm.updWv;

  btb_maint_ctrl #(.ENTRY_NUM(EN), .WRITE_NUM(WN), .ENTRY_BITS(EB), .CNT_BITS(16)) dut (
    .clk (clk), .rst (rst), .bus (bm.slave));
  btb_maint_ctrl #(.ENTRY_NUM(EN), .WRITE_NUM(WN), .ENTRY_BITS(EB), .CNT_BITS(4)) dut_sat (
    .clk (clk), .rst (rst), .bus (bs.slave));

  int checks = 0;
  int errors = 0;

  // Behavioural model: sweeping flag, beat number, flush-seen flag, ack, drops.
  bit m_busy;
  int m_beat;
  bit m_flush;
  bit m_ack;
  int m_drop;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [WN-1:0][IB-1:0] ewa;
    int ed, eds;
    ed  = (m_drop > 65535) ? 65535 : m_drop;
    eds = (m_drop > 15) ? 15 : m_drop;
    chk("busy",      128'(bm.busy),      128'(m_busy));
    chk("fetchHold", 128'(bm.fetchHold), 128'(m_busy));
    chk("flushAck",  128'(bm.flushAck),  128'(m_ack));
    chk("dropCnt",   128'(bm.dropCnt),   128'(ed));
    chk("dropCnt4",  128'(bs.dropCnt),   128'(eds));
    if (rst) begin
      chk("ramWe_rst", 128'(bm.ramWe), 128'(0));
    end else if (m_busy) begin
      for (int k = 0; k < WN; k++) ewa[k] = IB'(m_beat * WN + k);
      chk("sweep_we", 128'(bm.ramWe), 128'({WN{1'b1}}));
      chk("sweep_wa", 128'(bm.ramWa), 128'(ewa));
      chk("sweep_wv", 128'(bm.ramWv), 128'(0));
    end else begin
      chk("pass_we", 128'(bm.ramWe), 128'(bm.updWe));
      chk("pass_wa", 128'(bm.ramWa), 128'(bm.updWa));
      chk("pass_wv", 128'(bm.ramWv), 128'(bm.updWv));
    end
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_step();
    if (rst) begin
      m_busy = 1; m_beat = 0; m_flush = 0; m_ack = 0; m_drop = 0;
    end else if (m_busy) begin
      m_drop += $countones(bm.updWe);
      if (bm.flushReq) m_flush = 1;
      if (m_beat == BEATS - 1) begin
        m_busy = 0; m_ack = m_flush; m_beat = 0; m_flush = 0;
      end else begin
        m_beat++; m_ack = 0;
      end
    end else begin
      m_ack = 0;
      if (bm.flushReq) begin
        m_busy = 1; m_flush = 1; m_beat = 0;
      end
    end
  endtask

  task automatic set_in(input bit r, input bit fr, input logic [WN-1:0] we);
    rst         = r;
    bm.flushReq = fr;
    bm.updWe    = we;
    for (int k = 0; k < WN; k++) begin
      bm.updWa[k] = IB'($urandom_range(0, EN - 1));
      bm.updWv[k] = EB'({$urandom(), $urandom()});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // n cycles of random update traffic, no reset or flush.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 1'b0, WN'($urandom()));
      cycle();
    end
  endtask

  initial begin
    set_in(1'b1, 1'b0, '0);
    @(posedge clk);
    model_step();
    #1;
    // Reset held, then an init sweep with every update dropped.
    set_in(1'b1, 1'b0, 2'b11); cycle();
    for (int i = 0; i < BEATS; i++) begin
      set_in(1'b0, 1'b0, 2'b11); cycle();
    end
    run(3);
    // Directed pass-through in IDLE.
    set_in(1'b0, 1'b0, 2'b11);
    bm.updWa[0] = IB'(5);  bm.updWa[1] = IB'(9);
    bm.updWv[0] = EB'(48'hA); bm.updWv[1] = EB'(48'hB);
    cycle();
    // Plain flush.
    set_in(1'b0, 1'b1, WN'($urandom())); cycle();
    run(11);
    // Second flush request at beat 4 merges into the running sweep.
    set_in(1'b0, 1'b1, '0); cycle();
    run(3);
    set_in(1'b0, 1'b1, WN'($urandom())); cycle();
    run(7);
    // Reset at beat 5 of a flush sweep cancels the ack.
    set_in(1'b0, 1'b1, '0); cycle();
    run(4);
    set_in(1'b1, 1'b0, WN'($urandom())); cycle();
    run(12);
    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0), WN'($urandom()));
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
